// File: rtl/streaming_fifo_pkg.sv
// Shared constants and helpers for the streaming FIFO with watermark tracking.
package streaming_fifo_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 512;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port (read-before-write).
module fifo_sdp_ram
  import streaming_fifo_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth,
  parameter int unsigned Depth = DefaultDepth,
  parameter int unsigned AddrW = clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  // Write and registered read; no reset so the array maps onto BRAM/LUTRAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/streaming_fifo_wm.sv
// First-word-fall-through stream FIFO with occupancy, high-water mark, flush and
// almost-full/almost-empty flags.
module streaming_fifo_wm
  import streaming_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned CNT_W = clog2(DEPTH) + 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [WIDTH-1:0] in0_V_TDATA,
  input  logic             in0_V_TVALID,
  output logic             in0_V_TREADY,
  output logic [WIDTH-1:0] out_V_TDATA,
  output logic             out_V_TVALID,
  input  logic             out_V_TREADY,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] maxcount,
  input  logic             maxcount_clr,
  input  logic             flush,
  input  logic [CNT_W-1:0] afull_thresh,
  input  logic [CNT_W-1:0] aempty_thresh,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] maxcount_q, maxcount_d;
  logic             init_q;
  logic             byp_sel_q;
  logic [WIDTH-1:0] byp_data_q;
  logic [WIDTH-1:0] ram_rdata;
  logic             push, pop, byp_load;

  // init_q holds ready low until the first edge after reset release.
  assign in0_V_TREADY = init_q & (count_q < CNT_W'(DEPTH)) & ~flush;
  assign out_V_TVALID = (count_q != '0);
  assign push         = in0_V_TVALID & in0_V_TREADY;
  assign pop          = out_V_TVALID & out_V_TREADY;

  // The RAM reads the next head address, so its registered output already shows
  // the head after each edge. The one case it cannot cover is a word written on
  // the same edge into the slot that becomes the head; that word goes through
  // the holding register instead.
  assign byp_load = push & (wr_ptr_q == rd_ptr_d);

  // Next-state for pointers, occupancy and high-water mark.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Push is already blocked during flush; a pop only drains what is discarded anyway.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    maxcount_d = maxcount_q;
    if (maxcount_clr) begin
      maxcount_d = count_d;
    end else if (count_d > maxcount_q) begin
      maxcount_d = count_d;
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      init_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      maxcount_q <= '0;
      byp_sel_q  <= 1'b0;
    end else begin
      init_q     <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      maxcount_q <= maxcount_d;
      byp_sel_q  <= byp_load;
    end
  end

  // Holding register for words that become the head on the edge they are written.
  always_ff @(posedge ap_clk) begin
    if (byp_load) begin
      byp_data_q <= in0_V_TDATA;
    end
  end

  fifo_sdp_ram #(
    .Width(WIDTH),
    .Depth(DEPTH),
    .AddrW(AW)
  ) u_ram (
    .clk_i    (ap_clk),
    .wr_en_i  (push),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(in0_V_TDATA),
    .rd_addr_i(rd_ptr_d),
    .rd_data_o(ram_rdata)
  );

  assign out_V_TDATA  = byp_sel_q ? byp_data_q : ram_rdata;
  assign count        = count_q;
  assign maxcount     = maxcount_q;
  assign almost_full  = (count_q >= afull_thresh);
  assign almost_empty = (count_q <= aempty_thresh);

endmodule

// File: tb/tb_streaming_fifo_wm.sv
// Directed bench for streaming_fifo_wm: a DEPTH=4 instance for full/reset corners
// and a DEPTH=16 instance for a long random-handshake stream, watermark and flush.
module tb_streaming_fifo_wm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DEPTH=4, WIDTH=8 instance
  logic [7:0] a_din, a_dout;
  logic       a_ivld, a_irdy, a_ovld, a_ordy, a_mclr, a_flush, a_af, a_ae;
  logic [2:0] a_cnt, a_max, a_aft, a_aet;

  // DEPTH=16, WIDTH=16 instance
  logic [15:0] b_din, b_dout;
  logic        b_ivld, b_irdy, b_ovld, b_ordy, b_mclr, b_flush, b_af, b_ae;
  logic [4:0]  b_cnt, b_max, b_aft, b_aet;

  int n_cmp = 0;
  int n_err = 0;
  int sent, rcvd, mcnt, cyc;
  logic [15:0] q[$];
  logic [15:0] exp_w;

  streaming_fifo_wm #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_TDATA(a_din), .in0_V_TVALID(a_ivld), .in0_V_TREADY(a_irdy),
    .out_V_TDATA(a_dout), .out_V_TVALID(a_ovld), .out_V_TREADY(a_ordy),
    .count(a_cnt), .maxcount(a_max), .maxcount_clr(a_mclr), .flush(a_flush),
    .afull_thresh(a_aft), .aempty_thresh(a_aet),
    .almost_full(a_af), .almost_empty(a_ae)
  );

  streaming_fifo_wm #(.WIDTH(16), .DEPTH(16)) u_dut16 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_TDATA(b_din), .in0_V_TVALID(b_ivld), .in0_V_TREADY(b_irdy),
    .out_V_TDATA(b_dout), .out_V_TVALID(b_ovld), .out_V_TREADY(b_ordy),
    .count(b_cnt), .maxcount(b_max), .maxcount_clr(b_mclr), .flush(b_flush),
    .afull_thresh(b_aft), .aempty_thresh(b_aet),
    .almost_full(b_af), .almost_empty(b_ae)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_din = '0; a_ivld = 0; a_ordy = 0; a_mclr = 0; a_flush = 0; a_aft = 3'd3; a_aet = 3'd0;
    b_din = '0; b_ivld = 0; b_ordy = 0; b_mclr = 0; b_flush = 0; b_aft = 5'd0; b_aet = 5'd0;

    // Reset values
    #2;
    check_eq("rst_cnt", a_cnt, 0);
    check_eq("rst_max", a_max, 0);
    check_eq("rst_ovld", a_ovld, 0);
    check_eq("rst_irdy", a_irdy, 0);
    check_eq("rst_ae", a_ae, 1);
    check_eq("rst_af", a_af, 0);
    check_eq("rst_af_thr0", b_af, 1);
    #10 rst_n = 1'b1;
    #1;
    check_eq("irdy_before_edge", a_irdy, 0);
    step();
    check_eq("irdy_after_edge", a_irdy, 1);

    // Fill DEPTH=4 with 0x11..0x44, consumer stalled
    a_ivld = 1;
    for (int i = 0; i < 4; i++) begin
      a_din = 8'h11 * 8'(i + 1);
      step();
      if (i == 0) begin
        check_eq("lat1_ovld", a_ovld, 1);
        check_eq("lat1_data", a_dout, 8'h11);
      end
    end
    a_ivld = 0;
    check_eq("full_cnt", a_cnt, 4);
    check_eq("full_irdy", a_irdy, 0);
    check_eq("full_max", a_max, 4);
    check_eq("full_head", a_dout, 8'h11);
    check_eq("full_af", a_af, 1);

    // Pop at full with a push offered: push must not sneak in
    a_ordy = 1; a_ivld = 1; a_din = 8'h55;
    step();
    check_eq("popfull_cnt", a_cnt, 3);
    check_eq("popfull_head", a_dout, 8'h22);
    a_ordy = 0;
    check_eq("popfull_irdy", a_irdy, 1);
    step();
    a_ivld = 0;
    check_eq("refill_cnt", a_cnt, 4);
    check_eq("stall_head", a_dout, 8'h22);

    // Drain across the pointer wrap
    a_ordy = 1;
    for (int i = 0; i < 4; i++) begin
      exp_w = (i == 3) ? 16'h55 : 16'(8'h22 + 8'h11 * 8'(i));
      check_eq("drain_data", a_dout, exp_w);
      step();
    end
    a_ordy = 0;
    check_eq("drain_ovld", a_ovld, 0);
    check_eq("drain_cnt", a_cnt, 0);

    // Long random-handshake stream on DEPTH=16 against a queue model
    sent = 0; rcvd = 0; mcnt = 0; cyc = 0;
    while (rcvd < 10000 && cyc < 60000 && n_err < 20) begin
      b_ivld = (sent < 10000) && ($urandom_range(0, 1) == 1);
      b_din  = 16'(sent) ^ 16'h5a3c;
      b_ordy = ($urandom_range(0, 1) == 1);
      #1;
      check_eq("s_cnt", b_cnt, mcnt);
      check_eq("s_irdy", b_irdy, (mcnt < 16));
      check_eq("s_ovld", b_ovld, (mcnt != 0));
      if (b_ovld && b_ordy) begin
        if (q.size() > 0) begin
          exp_w = q.pop_front();
          check_eq("s_data", b_dout, exp_w);
        end else begin
          check_eq("s_underflow", 1, 0);
        end
        rcvd++;
        mcnt--;
      end
      if (b_ivld && b_irdy) begin
        q.push_back(b_din);
        sent++;
        mcnt++;
      end
      step();
      cyc++;
    end
    b_ivld = 0; b_ordy = 0;
    check_eq("s_words", rcvd, 10000);
    check_eq("s_end_cnt", b_cnt, 0);

    // High-water mark: clear, fill to 5, drain to 3, clear with simultaneous push
    b_mclr = 1;
    step();
    b_mclr = 0;
    check_eq("wm_clr0", b_max, 0);
    b_ivld = 1;
    for (int i = 0; i < 5; i++) begin
      b_din = 16'h0100 + 16'(i);
      step();
    end
    b_ivld = 0;
    check_eq("wm_max5", b_max, 5);
    b_ordy = 1;
    step();
    step();
    b_ordy = 0;
    check_eq("wm_cnt3", b_cnt, 3);
    check_eq("wm_hold5", b_max, 5);
    check_eq("wm_head", b_dout, 16'h0102);
    b_mclr = 1; b_ivld = 1; b_din = 16'h0105;
    step();
    b_mclr = 0; b_ivld = 0;
    check_eq("wm_clr_cnt", b_cnt, 4);
    check_eq("wm_clr_max", b_max, 4);

    // Thresholds and flush
    b_aft = 5'd6; b_aet = 5'd2;
    #1;
    check_eq("thr4_af", b_af, 0);
    check_eq("thr4_ae", b_ae, 0);
    b_ivld = 1;
    b_din = 16'h0106;
    step();
    b_din = 16'h0107;
    step();
    b_ivld = 0;
    check_eq("thr6_cnt", b_cnt, 6);
    check_eq("thr6_af", b_af, 1);
    check_eq("thr6_ae", b_ae, 0);
    b_flush = 1; b_ordy = 1;
    #1;
    check_eq("flush_irdy", b_irdy, 0);
    step();
    b_flush = 0; b_ordy = 0;
    check_eq("flush_cnt", b_cnt, 0);
    check_eq("flush_ae", b_ae, 1);
    check_eq("flush_af", b_af, 0);
    check_eq("flush_ovld", b_ovld, 0);
    check_eq("flush_max", b_max, 6);
    b_ivld = 1; b_din = 16'hbeef;
    step();
    b_ivld = 0;
    check_eq("postflush_ovld", b_ovld, 1);
    check_eq("postflush_data", b_dout, 16'hbeef);

    // Asynchronous reset mid-stream with three words held
    a_ivld = 1;
    for (int i = 0; i < 3; i++) begin
      a_din = 8'h61 + 8'(i);
      step();
    end
    a_ivld = 0;
    check_eq("pre_rst_cnt", a_cnt, 3);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_cnt", a_cnt, 0);
    check_eq("arst_ovld", a_ovld, 0);
    check_eq("arst_irdy", a_irdy, 0);
    check_eq("arst_max", a_max, 0);
    check_eq("arst_ae", a_ae, 1);
    check_eq("arst_b_cnt", b_cnt, 0);
    #2 rst_n = 1'b1;
    step();
    check_eq("post_rst_ovld", a_ovld, 0);
    check_eq("post_rst_irdy", a_irdy, 1);
    a_ordy = 1;
    step();
    check_eq("no_stale_ovld", a_ovld, 0);
    a_ordy = 0; a_ivld = 1; a_din = 8'h70;
    step();
    a_ivld = 0;
    check_eq("post_rst_data", a_dout, 8'h70);
    check_eq("post_rst_cnt", a_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
